// File: rtl/game_pkg.sv
// Shared types and constants for the game flow controller.
// Holds the FSM state encoding, bus widths and default goal location.
package game_pkg;

    localparam int STATE_W    = 3;
    localparam int LEVEL_W    = 4;
    localparam int POS_W      = 12;
    localparam int SCORE_W    = 24;
    localparam int DEF_GOAL_X = 482;
    localparam int DEF_GOAL_Y = 108;

    typedef enum logic [STATE_W-1:0] {
        S_TITLE = 3'd0,
        S_LOAD  = 3'd1,
        S_PLAY  = 3'd2,
        S_CLEAR = 3'd3,
        S_WIN   = 3'd4,
        S_OVER  = 3'd5
    } state_t;

    // Unsigned distance check with one extra bit so nothing wraps.
    function automatic logic near(
        input logic [POS_W:0] a,
        input logic [POS_W:0] b,
        input logic [POS_W:0] tol
    );
        logic [POS_W:0] d;
        d = (a >= b) ? (a - b) : (b - a);
        return d <= tol;
    endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchronizer followed by a rising-edge detector.
// Emits a single-clock pulse per press, however long it is held.
module btn_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic pulse
);

    logic [2:0] sh_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_q <= '0;
        end else begin
            sh_q <= {sh_q[1:0], btn};
        end
    end

    assign pulse = sh_q[1] & ~sh_q[2];

endmodule

// File: rtl/game_flow_ctl.sv
// Top-level game sequencer: title, load, play, clear, win, over.
// Define GAME_FLOW_TIMER_EN to add the per-level frame timer and OVER.
module game_flow_ctl
    import game_pkg::*;
#(
    parameter int NUM_LEVELS        = 4,
    parameter int LOAD_CYCLES       = 4,
    parameter int PAUSE_FRAMES      = 120,
    parameter int GOAL_X            = DEF_GOAL_X,
    parameter int GOAL_Y            = DEF_GOAL_Y,
    parameter int GOAL_TOL          = 8,
    parameter int TIME_LIMIT_FRAMES = 3600
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               vblnk_in,
    input  logic               btn_center,
    input  logic [POS_W-1:0]   hero_x_pos,
    input  logic [POS_W-1:0]   hero_y_pos,
    input  logic [SCORE_W-1:0] score,
    input  logic [SCORE_W-1:0] score_req,
    output logic [LEVEL_W-1:0] level,
    output logic               hero_rst,
    output logic               map_rst,
    output logic [STATE_W-1:0] game_state,
    output logic               overlay_en,
    output logic [POS_W-1:0]   time_left
);

    localparam int LC_W = $clog2(LOAD_CYCLES + 1);
    localparam int FC_W = $clog2(PAUSE_FRAMES + 1);
    localparam logic [LEVEL_W-1:0] LAST_LVL = LEVEL_W'(NUM_LEVELS - 1);

    state_t             state_q, state_d;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic [LC_W-1:0]    lcnt_q, lcnt_d;
    logic [FC_W-1:0]    fcnt_q, fcnt_d;
    logic               blk_rst_q;
    logic               btn_pulse;
    logic               vb_q, vb_q2;
    logic               frame_tick;
    logic               goal_q;
    logic               time_out;

    btn_sync_edge u_btn (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_center),
        .pulse (btn_pulse)
    );

    assign frame_tick = vb_q & ~vb_q2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vb_q   <= 1'b0;
            vb_q2  <= 1'b0;
            goal_q <= 1'b0;
        end else begin
            vb_q   <= vblnk_in;
            vb_q2  <= vb_q;
            goal_q <= near(13'(hero_x_pos), 13'(GOAL_X), 13'(GOAL_TOL))
                   && near(13'(hero_y_pos), 13'(GOAL_Y), 13'(GOAL_TOL))
                   && (score >= score_req);
        end
    end

`ifdef GAME_FLOW_TIMER_EN
    localparam logic [POS_W-1:0] TIME_INIT = POS_W'(TIME_LIMIT_FRAMES);

    logic [POS_W-1:0] time_q, time_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            time_q <= '0;
        end else begin
            time_q <= time_d;
        end
    end

    assign time_out  = (time_q == '0);
    assign time_left = time_q;
`else
    assign time_out  = 1'b0;
    assign time_left = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_TITLE;
            level_q   <= '0;
            lcnt_q    <= '0;
            fcnt_q    <= '0;
            blk_rst_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            level_q   <= level_d;
            lcnt_q    <= lcnt_d;
            fcnt_q    <= fcnt_d;
            blk_rst_q <= (state_d == S_LOAD);
        end
    end

    always_comb begin
        state_d = state_q;
        level_d = level_q;
        lcnt_d  = '0;
        fcnt_d  = fcnt_q;
`ifdef GAME_FLOW_TIMER_EN
        time_d  = time_q;
`endif
        case (state_q)
            S_TITLE: begin
                level_d = '0;
                if (btn_pulse) state_d = S_LOAD;
            end
            S_LOAD: begin
`ifdef GAME_FLOW_TIMER_EN
                time_d = TIME_INIT;
`endif
                if (lcnt_q == LC_W'(LOAD_CYCLES - 1)) begin
                    state_d = S_PLAY;
                end else begin
                    lcnt_d = lcnt_q + 1'b1;
                end
            end
            S_PLAY: begin
                fcnt_d = '0;
`ifdef GAME_FLOW_TIMER_EN
                if (frame_tick && !time_out) time_d = time_q - 1'b1;
`endif
                // Reaching the goal beats a simultaneous timeout.
                if (goal_q) begin
                    state_d = S_CLEAR;
                end else if (time_out) begin
                    state_d = S_OVER;
                end
            end
            S_CLEAR: begin
                if (frame_tick) begin
                    if (fcnt_q == FC_W'(PAUSE_FRAMES - 1)) begin
                        fcnt_d = '0;
                        if (level_q == LAST_LVL) begin
                            state_d = S_WIN;
                        end else begin
                            level_d = level_q + 1'b1;
                            state_d = S_LOAD;
                        end
                    end else begin
                        fcnt_d = fcnt_q + 1'b1;
                    end
                end
            end
            S_WIN, S_OVER: begin
                if (btn_pulse) begin
                    state_d = S_TITLE;
                    level_d = '0;
                end
            end
            default: state_d = S_TITLE;
        endcase
    end

    assign level      = level_q;
    assign game_state = state_q;
    assign hero_rst   = blk_rst_q;
    assign map_rst    = blk_rst_q;
    assign overlay_en = (state_q != S_PLAY);

endmodule
